// File: rtl/ps2_key_rx_if.sv
// ps2_key_rx_if
// Bundles the PS/2 keyboard lines and the decoded key-event outputs of
// ps2_key_rx so that producer and consumer share one port.
//   ps2_clk, ps2_data : raw keyboard clock/data (asynchronous to clk_sys)
//   ps2_key           : 65-bit event word, [64] toggles once per sequence
//   rx_byte           : last correctly received byte
//   rx_strobe         : one-cycle pulse when rx_byte updates
//   frame_err         : one-cycle pulse on parity/stop error or timeout
// Modports:
//   master : the receiver (consumes lines, drives event outputs)
//   slave  : board side / decoder (drives lines, consumes event outputs)
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [64:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic        frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output rx_byte,
    output rx_strobe,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  rx_byte,
    input  rx_strobe,
    input  frame_err
  );
endinterface

// File: rtl/ps2_key_rx.sv
// ps2_key_rx
// PS/2 keyboard receiver: synchronizes and de-glitches the keyboard lines,
// deserializes 11-bit frames with odd parity, groups E0/F0/E1 prefixed bytes
// into complete key sequences and publishes each one on ps2_key with a
// toggle flag in bit 64.
// Ports:
//   clk_sys : system clock, the only clock
//   reset_n : synchronous active-low reset
//   bus     : ps2_key_rx_if.master (ps2_clk/ps2_data in; ps2_key, rx_byte,
//             rx_strobe, frame_err out)
// Parameters:
//   FILTER_LEN : equal synchronized samples needed to accept a line change
//   TIMEOUT    : cycles without a clock fall before an active frame or
//                partial sequence is aborted
module ps2_key_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  ps2_key_rx_if.master bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BITS, PARITY, STOP} state_t;

  // line index 0 = keyboard clock, 1 = keyboard data
  logic [1:0] line_raw;
  logic [1:0] line_filt;

  assign line_raw = {bus.ps2_data, bus.ps2_clk};

  // Per line: 2-flop synchronizer followed by a run-length filter. The filter
  // output follows the synchronized input only after FILTER_LEN consecutive
  // samples that disagree with the current output.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0]    sync_reg;
      logic [FW-1:0] run_reg;
      logic          filt_reg;

      always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
          sync_reg <= 2'b11;
          run_reg  <= '0;
          filt_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[0], line_raw[gi]};
          if (sync_reg[1] == filt_reg) begin
            run_reg <= '0;
          end else if (run_reg == FW'(FILTER_LEN - 1)) begin
            filt_reg <= sync_reg[1];
            run_reg  <= '0;
          end else begin
            run_reg <= run_reg + 1'b1;
          end
        end
      end

      assign line_filt[gi] = filt_reg;
    end
  endgenerate

  logic clk_prev_reg;
  logic fall;
  logic data_f;

  assign fall   = clk_prev_reg & ~line_filt[0];
  assign data_f = line_filt[1];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) clk_prev_reg <= 1'b1;
    else          clk_prev_reg <= line_filt[0];
  end

  state_t        state_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] tmo_reg;
  logic [63:0]   seq_reg;
  logic [3:0]    len_reg;
  logic          pause_reg;
  logic [64:0]   key_reg;
  logic [7:0]    rx_byte_reg;
  logic          rx_strobe_reg;
  logic          frame_err_reg;

  // Sequence decision for the byte currently held in shift_reg, used when the
  // stop bit arrives.
  logic [63:0] seq_app;
  logic [3:0]  len_app;
  logic        in_pause;
  logic        seq_continue;
  logic        seq_done;
  logic        frame_ok;

  always_comb begin
    seq_app      = {seq_reg[55:0], shift_reg};
    len_app      = len_reg + 4'd1;
    frame_ok     = data_f & ((^shift_reg) ^ parity_reg);
    // E1 as the first byte starts Pause: every following byte is taken
    // verbatim until eight bytes have been collected.
    in_pause     = pause_reg | ((len_reg == 4'd0) && (shift_reg == 8'hE1));
    seq_continue = 1'b0;
    if (in_pause)
      seq_continue = 1'b1;
    else if ((shift_reg == 8'hE0) || (shift_reg == 8'hF0))
      seq_continue = 1'b1;
    // PrtScr sends two extended codes per action; keep the first half open.
    else if ((shift_reg == 8'h12) && (len_reg == 4'd1) && (seq_reg == 64'hE0))
      seq_continue = 1'b1;
    else if ((shift_reg == 8'h7C) && (len_reg == 4'd2) && (seq_reg == 64'hE0F0))
      seq_continue = 1'b1;
    seq_done = !seq_continue || (len_app == 4'd8);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'h00;
      parity_reg    <= 1'b0;
      tmo_reg       <= '0;
      seq_reg       <= 64'h0;
      len_reg       <= 4'd0;
      pause_reg     <= 1'b0;
      key_reg       <= 65'h0;
      rx_byte_reg   <= 8'h00;
      rx_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;

      if (fall) begin
        // a fall always wins over a simultaneous timeout
        tmo_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (!data_f) begin
              state_reg   <= BITS;
              bit_cnt_reg <= 4'd0;
            end
          end
          BITS: begin
            shift_reg   <= {data_f, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= data_f;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (frame_ok) begin
              rx_byte_reg   <= shift_reg;
              rx_strobe_reg <= 1'b1;
              if (seq_done) begin
                key_reg   <= {~key_reg[64], seq_app};
                seq_reg   <= 64'h0;
                len_reg   <= 4'd0;
                pause_reg <= 1'b0;
              end else begin
                seq_reg   <= seq_app;
                len_reg   <= len_app;
                pause_reg <= in_pause;
              end
            end else begin
              frame_err_reg <= 1'b1;
              seq_reg       <= 64'h0;
              len_reg       <= 4'd0;
              pause_reg     <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end else if ((state_reg != IDLE) || (len_reg != 4'd0)) begin
        if (tmo_reg == TW'(TIMEOUT)) begin
          state_reg     <= IDLE;
          seq_reg       <= 64'h0;
          len_reg       <= 4'd0;
          pause_reg     <= 1'b0;
          frame_err_reg <= 1'b1;
          tmo_reg       <= '0;
        end else begin
          tmo_reg <= tmo_reg + 1'b1;
        end
      end else begin
        tmo_reg <= '0;
      end
    end
  end

  assign bus.ps2_key   = key_reg;
  assign bus.rx_byte   = rx_byte_reg;
  assign bus.rx_strobe = rx_strobe_reg;
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx
// Drives PS/2 frames into ps2_key_rx and compares received bytes, key events
// and error pulses with a byte-queue model of the keyboard sequence rules.
module tb_ps2_key_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 12;
  localparam int SETTLE     = FILTER_LEN + 10;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  ps2_key_rx_if bus ();

  ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // observed activity
  logic [64:0] evt_q[$];
  logic [7:0]  strobe_q[$];
  int          err_seen   = 0;
  int          both_seen  = 0;
  int          misalign   = 0;
  logic        key_prev   = 1'b0;
  bit          hold_evt   = 1'b0;

  // expected activity
  logic [64:0] exp_evt[$];
  logic [7:0]  exp_strobe[$];
  int          exp_err = 0;
  logic [7:0]  mq[$];
  bit          mpause = 1'b0;
  logic        mtog   = 1'b0;

  always @(negedge clk_sys) begin
    if (bus.rx_strobe) strobe_q.push_back(bus.rx_byte);
    if (bus.frame_err) err_seen++;
    if (bus.rx_strobe && bus.frame_err) both_seen++;
    if (!hold_evt && (bus.ps2_key[64] !== key_prev)) begin
      evt_q.push_back(bus.ps2_key);
      if (!bus.rx_strobe) misalign++;
    end
    key_prev = bus.ps2_key[64];
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sequence rules expressed on a queue of whole bytes.
  task automatic model_byte(input logic [7:0] b);
    bit cont;
    logic [63:0] v;
    mq.push_back(b);
    if (mpause || (mq.size() == 1 && b == 8'hE1)) begin
      mpause = 1'b1;
      cont = 1'b1;
    end else begin
      cont = (b == 8'hE0) || (b == 8'hF0) ||
             (mq.size() == 2 && mq[0] == 8'hE0 && b == 8'h12) ||
             (mq.size() == 3 && mq[0] == 8'hE0 && mq[1] == 8'hF0 && b == 8'h7C);
    end
    if (!cont || mq.size() == 8) begin
      v = 64'h0;
      foreach (mq[i]) v = {v[55:0], mq[i]};
      mtog = ~mtog;
      exp_evt.push_back({mtog, v});
      mq.delete();
      mpause = 1'b0;
    end
  endtask

  task automatic model_error();
    exp_err++;
    mq.delete();
    mpause = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      repeat (HALF) @(negedge clk_sys);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      bus.ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk_sys);
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(bits, 11);
    if (bad_par) model_error();
    else begin
      exp_strobe.push_back(b);
      model_byte(b);
    end
    repeat (SETTLE) @(negedge clk_sys);
  endtask

  task automatic compare_all(input string tag);
    check({tag, " events"}, 65'(evt_q.size()), 65'(exp_evt.size()));
    while (evt_q.size() > 0 && exp_evt.size() > 0)
      check({tag, " ps2_key"}, evt_q.pop_front(), exp_evt.pop_front());
    check({tag, " strobes"}, 65'(strobe_q.size()), 65'(exp_strobe.size()));
    while (strobe_q.size() > 0 && exp_strobe.size() > 0)
      check({tag, " rx_byte"}, 65'(strobe_q.pop_front()), 65'(exp_strobe.pop_front()));
    check({tag, " frame_err"}, 65'(err_seen), 65'(exp_err));
    evt_q.delete();
    exp_evt.delete();
    strobe_q.delete();
    exp_strobe.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ps2_key"},   bus.ps2_key, 65'h0);
    check({tag, " rx_byte"},   65'(bus.rx_byte), 65'h0);
    check({tag, " rx_strobe"}, 65'(bus.rx_strobe), 65'h0);
    check({tag, " frame_err"}, 65'(bus.frame_err), 65'h0);
  endtask

  initial begin
    logic [7:0] rb;
    bit bad;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    // reset state
    repeat (4) @(negedge clk_sys);
    check_zero("in_reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    check_zero("after_reset");

    // single make code
    send_frame(8'h1C, 1'b0);
    compare_all("make_1C");
    check("key_1C", bus.ps2_key, {1'b1, 64'h1C});

    // break code
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    compare_all("break_1C");

    // extended release then PrtScr make
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h7C, 1'b0);
    compare_all("ext_prtscr");

    // Pause
    send_frame(8'hE1, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'h77, 1'b0);
    send_frame(8'hE1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h77, 1'b0);
    compare_all("pause");
    check("key_pause", bus.ps2_key, {1'b1, 64'hE11477E1F014F077});

    // parity error, then a clean frame
    send_frame(8'h1C, 1'b1);
    compare_all("parity_err");
    check("key_kept", bus.ps2_key, {1'b1, 64'hE11477E1F014F077});
    send_frame(8'h1C, 1'b0);
    compare_all("after_parity");

    // truncated frame: start + 5 data bits, then silence
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
    repeat (TIMEOUT + 100) @(negedge clk_sys);
    model_error();
    compare_all("timeout");
    send_frame(8'h29, 1'b0);
    compare_all("after_timeout");
    check("key_29", 65'(bus.ps2_key[63:0]), 65'h29);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'hE1;
        3: rb = 8'h12;
        4: rb = 8'h7C;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 7) == 0);
      send_frame(rb, bad);
      compare_all($sformatf("rand%0d", n));
    end

    // E0, then reset in the middle of the next frame
    send_frame(8'hE0, 1'b0);
    compare_all("pre_reset");
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
    hold_evt = 1'b1;
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    mq.delete();
    mpause = 1'b0;
    mtog = 1'b0;
    @(negedge clk_sys);
    hold_evt = 1'b0;
    check_zero("mid_reset");
    repeat (TIMEOUT + 100) @(negedge clk_sys);
    compare_all("post_reset");

    check("strobe_err_overlap", 65'(both_seen), 65'h0);
    check("key_strobe_align", 65'(misalign), 65'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
